sin_24b_phase_gen: RTL
======================

Name: sin_24b_phase_gen

Overview:
Phase-sweep generator sitting directly upstream of sin_24b. It produces the 24-bit phase stream that drives sin_24b's in0 port, replacing file-driven stimulus with an on-chip numerically controlled oscillator. It emits a programmable burst of phases (start phase, frequency control word, sample count) over a valid/ready handshake. Downstream logic registers sin_24b's 25-bit result on each accepted phase.

Parameters:
PHASE_W, 24, phase/accumulator width; must match sin_24b input width.
CNT_W, 20, burst-length counter width (max 1,048,575 samples; covers 1,000,000-sample runs).
LFSR_W, 8, dither LFSR width (used only with the optional feature).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
cfg_valid  in  1  configuration offered.
cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready.
cfg_fcw  in  PHASE_W  frequency control word (phase increment).
cfg_phase0  in  PHASE_W  first phase of burst.
cfg_count  in  CNT_W  number of samples in burst.
start  in  1  single-cycle burst launch.
abort  in  1  terminate burst immediately.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse after last sample accepted.
out_valid  out  1  phase sample valid.
out_ready  in  1  downstream accepts sample.
out_phase  out  PHASE_W  phase to sin_24b in0.
out_wrap  out  1  this sample's phase wrapped past 2^PHASE_W.
out_last  out  1  this is the final sample of the burst.

Behaviour:
- One clock; reset is synchronous and active-low. While rst_n=0 at a clk edge:
  - cfg_ready=0, busy=0, done=0, out_valid=0, out_phase=0, out_wrap=0, out_last=0.
  - Config registers clear (fcw=0, phase0=0, count=0); FSM -> IDLE.
  - cfg_ready rises the cycle after rst_n goes high.
- FSM states: IDLE, RUN.
- IDLE:
  - cfg_ready=1; a handshake latches fcw, phase0 and count.
  - start=1 with latched count>0: next cycle RUN, busy=1, out_valid=1, out_phase=phase0, out_wrap=0, remaining=count, out_last=(count==1).
  - start=1 with count==0: no samples, done pulses next cycle, stays IDLE.
  - start and a cfg handshake in the same cycle: the new config is latched and used by that start.
- RUN:
  - cfg_ready=0; cfg_valid and start are ignored.
  - Handshake (out_valid & out_ready) with remaining>1:
    - {carry, acc} = acc + fcw, modulo 2^PHASE_W.
    - out_wrap <= carry; remaining--; out_last <= (remaining==2).
  - Handshake with remaining==1: out_valid<=0, busy<=0, done<=1 for one cycle, FSM -> IDLE.
- Throughput: one sample per cycle while out_ready=1. No bubbles between consecutive samples.
- Backpressure: while out_valid=1 and out_ready=0, out_phase, out_wrap and out_last hold stable. Accumulator and counter do not advance.
- abort=1 in RUN (takes priority over a handshake in the same cycle): next cycle IDLE, out_valid=0, busy=0, no done pulse. Config registers are retained.
- abort in IDLE has no effect.
- rst_n low mid-burst: reset values take effect on that edge; no done pulse.

Optional Feature:
PHASE_DITHER_EN
- Defined:
  - Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded 8'h01 on reset and on each start.
  - The LFSR advances once per accepted sample.
  - out_phase = acc + zero-extended lfsr (modulo 2^PHASE_W). out_wrap still reflects only the accumulator carry.
- Undefined: no LFSR logic; out_phase = acc exactly.

Test Plan:
- Reset: rst_n=0 for 3 cycles, arbitrary inputs -> all outputs 0. cfg_ready=1 on the first cycle after rst_n=1.
- Basic sweep: fcw=24'h100000, phase0=0, count=20, out_ready=1 -> phases 0x000000..0xF00000 with out_wrap=0; the 17th sample is 0x000000 with out_wrap=1; the 20th is 0x300000 with out_last=1. done pulses the next cycle, then busy=0.
- Backpressure: fcw=1, phase0=24'hFFFFFE, count=4, out_ready toggling 1,0,0,1,1,0,1 -> phases FFFFFE, FFFFFF, 000000 (wrap=1), 000001. Each value is held while ready=0; exactly 4 handshakes, then done.
- Zero count and config lockout: count=0, start -> done pulses, out_valid never rises. Start count=5; in RUN, present cfg_valid with fcw=7 -> cfg_ready=0 and the burst keeps the original fcw.
- Abort: count=100, out_ready=1, abort on the 10th sample -> out_valid=0 the next cycle, no done. A fresh start replays from phase0.
- Dither (macro defined): fcw=0, phase0=0, count=3 -> out_phase 0x000001, 0x000002 (after LFSR step), then the next LFSR value. With the macro undefined, the same run gives 0, 0, 0.

Source files
------------

// File: rtl/sin_24b_phase_gen.sv
// Numerically controlled phase-burst generator feeding sin_24b's in0 port.
// Optional build macro PHASE_DITHER_EN adds an 8-bit Galois LFSR dither to out_phase.

module sin_24b_phase_gen #(
   parameter int PHASE_W = 24,
   parameter int CNT_W   = 20,
   parameter int LFSR_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [PHASE_W-1:0] cfg_fcw,
   input  logic [PHASE_W-1:0] cfg_phase0,
   input  logic [CNT_W-1:0]   cfg_count,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PHASE_W-1:0] out_phase,
   output logic               out_wrap,
   output logic               out_last
);

   // Handshake rule for both channels: a transfer happens on a rising edge
   // where valid and ready are both high; the payload is stable from the cycle
   // valid rises until that edge, and the source never withdraws valid early.

   if (PHASE_W < 2 || CNT_W < 2 || LFSR_W < 2 || LFSR_W > PHASE_W) begin : g_param_check
      $error("sin_24b_phase_gen: unsupported parameter combination");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state;
   logic [PHASE_W-1:0] fcw_q;
   logic [PHASE_W-1:0] phase0_q;
   logic [CNT_W-1:0]   count_q;
   logic [PHASE_W-1:0] acc;
   logic [CNT_W-1:0]   remaining;

   logic               cfg_hs;
   logic               out_hs;
   logic [PHASE_W-1:0] eff_fcw;
   logic [PHASE_W-1:0] eff_phase0;
   logic [CNT_W-1:0]   eff_count;
   logic [PHASE_W:0]   acc_sum;
   logic [PHASE_W-1:0] launch_phase;
   logic [PHASE_W-1:0] step_phase;

   assign cfg_hs  = cfg_valid & cfg_ready;
   assign out_hs  = out_valid & out_ready;

   // A start in the same cycle as a config handshake uses the incoming config.
   assign eff_fcw    = cfg_hs ? cfg_fcw    : fcw_q;
   assign eff_phase0 = cfg_hs ? cfg_phase0 : phase0_q;
   assign eff_count  = cfg_hs ? cfg_count  : count_q;

   assign acc_sum = {1'b0, acc} + {1'b0, fcw_q};

`ifdef PHASE_DITHER_EN
   localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);
   // x^8+x^6+x^5+x^4+1: feedback folds into bits 6, 5, 4 and 0.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(8'h71);

   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] lfsr_step;

   assign lfsr_step    = {lfsr[LFSR_W-2:0], 1'b0} ^ (lfsr[LFSR_W-1] ? LFSR_TAPS : '0);
   assign launch_phase = eff_phase0 + PHASE_W'(LFSR_SEED);
   assign step_phase   = acc_sum[PHASE_W-1:0] + PHASE_W'(lfsr_step);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (state == IDLE && start) begin
         lfsr <= LFSR_SEED;
      end else if (state == RUN && out_hs && !abort) begin
         lfsr <= lfsr_step;
      end
   end
`else
   assign launch_phase = eff_phase0;
   assign step_phase   = acc_sum[PHASE_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cfg_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_phase <= '0;
         out_wrap  <= 1'b0;
         out_last  <= 1'b0;
         fcw_q     <= '0;
         phase0_q  <= '0;
         count_q   <= '0;
         acc       <= '0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cfg_ready <= 1'b1;
               if (cfg_hs) begin
                  fcw_q    <= cfg_fcw;
                  phase0_q <= cfg_phase0;
                  count_q  <= cfg_count;
               end
               if (start) begin
                  if (eff_count != '0) begin
                     state     <= RUN;
                     cfg_ready <= 1'b0;
                     busy      <= 1'b1;
                     out_valid <= 1'b1;
                     out_phase <= launch_phase;
                     out_wrap  <= 1'b0;
                     out_last  <= (eff_count == CNT_W'(1));
                     acc       <= eff_phase0;
                     remaining <= eff_count;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               // abort outranks a handshake landing on the same edge
               if (abort) begin
                  state     <= IDLE;
                  cfg_ready <= 1'b1;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
               end else if (out_hs) begin
                  if (remaining == CNT_W'(1)) begin
                     state     <= IDLE;
                     cfg_ready <= 1'b1;
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     acc       <= acc_sum[PHASE_W-1:0];
                     out_phase <= step_phase;
                     out_wrap  <= acc_sum[PHASE_W];
                     remaining <= remaining - CNT_W'(1);
                     out_last  <= (remaining == CNT_W'(2));
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
